// File: rtl/lmul_pkg.sv
// Shared types and constants for the logarithmic-approximation multiplier pipeline.
// Bias, offset and canonical-NaN helpers are functions of the field widths.
package lmul_pkg;

   typedef enum logic [1:0] {
      K_NORM = 2'd0,
      K_ZERO = 2'd1,
      K_INF  = 2'd2,
      K_NAN  = 2'd3
   } kind_t;

   localparam int FLAG_ZERO = 0;
   localparam int FLAG_OVF  = 1;
   localparam int FLAG_NAN  = 2;
   localparam int N_FLAGS   = 3;

   function automatic int lmul_bias(input int e_bits);
      return (1 << (e_bits - 1)) - 1;
   endfunction

   // The correction term uses only the top l mantissa bits.
   function automatic int lmul_offset(input int m_bits);
      int l;
      if (m_bits <= 3)
         l = m_bits;
      else if (m_bits == 4)
         l = 3;
      else
         l = 4;
      return 1 << (m_bits - l);
   endfunction

   function automatic logic [31:0] lmul_nan(input int e_bits, input int m_bits);
      logic [31:0] r;
      r = (((32'd1 << e_bits) - 32'd1) << m_bits) | (32'd1 << (m_bits - 1));
      return r;
   endfunction

endpackage

// File: rtl/lmul_lane.sv
// One multiplier lane: combinational logic for the decode, add and classify stages.
// Stage registers live in lmul_pipe; each port group feeds/reads one register stage.
module lmul_lane
   import lmul_pkg::*;
#(
   parameter int E_BITS  = 8,
   parameter int M_BITS  = 7,
   parameter int EM_BITS = E_BITS + M_BITS,
   parameter int BITW    = EM_BITS + 1,
   parameter int SW      = EM_BITS + 2
) (
   input  logic [BITW-1:0]          a,
   input  logic [BITW-1:0]          b,
   output logic                     dec_sign,
   output logic [EM_BITS-1:0]       dec_em_a,
   output logic [EM_BITS-1:0]       dec_em_b,
   output kind_t                    dec_kind,
   input  logic [EM_BITS-1:0]       add_em_a,
   input  logic [EM_BITS-1:0]       add_em_b,
   output logic signed [SW-1:0]     add_sum,
   input  kind_t                    cls_kind,
   input  logic                     cls_sign,
   input  logic signed [SW-1:0]     cls_sum,
   output logic [BITW-1:0]          cls_p,
   output logic [N_FLAGS-1:0]       cls_flags
);

   localparam logic [SW-1:0]        ADJ      = SW'(lmul_offset(M_BITS) - (lmul_bias(E_BITS) << M_BITS));
   localparam logic signed [SW-1:0] OVF_TH   = SW'(((1 << E_BITS) - 1) << M_BITS);
   localparam logic signed [SW-1:0] MIN_NORM = SW'(1 << M_BITS);
   localparam logic [BITW-1:0]      QNAN     = BITW'(lmul_nan(E_BITS, M_BITS));
   localparam logic [EM_BITS-1:0]   INF_EM   = {{E_BITS{1'b1}}, {M_BITS{1'b0}}};

   logic [E_BITS-1:0] exp_a, exp_b;
   logic [M_BITS-1:0] man_a, man_b;
   logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

   assign exp_a = a[EM_BITS-1:M_BITS];
   assign exp_b = b[EM_BITS-1:M_BITS];
   assign man_a = a[M_BITS-1:0];
   assign man_b = b[M_BITS-1:0];

   assign a_zero = (exp_a == '0);
   assign b_zero = (exp_b == '0);
   assign a_inf  = (&exp_a) && (man_a == '0);
   assign b_inf  = (&exp_b) && (man_b == '0);
   assign a_nan  = (&exp_a) && (man_a != '0);
   assign b_nan  = (&exp_b) && (man_b != '0);

   assign dec_sign = a[BITW-1] ^ b[BITW-1];
   assign dec_em_a = a[EM_BITS-1:0];
   assign dec_em_b = b[EM_BITS-1:0];

   // Precedence: NaN (incl. Inf x zero) over Inf over flushed zero.
   always_comb begin
      dec_kind = K_NORM;
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
         dec_kind = K_NAN;
      else if (a_inf || b_inf)
         dec_kind = K_INF;
      else if (a_zero || b_zero)
         dec_kind = K_ZERO;
   end

   // Two guard bits hold the full range; ADJ folds in -BIAS<<M and +OFFSET.
   assign add_sum = $signed({2'b00, add_em_a} + {2'b00, add_em_b} + ADJ);

   always_comb begin
      cls_p     = {cls_sign, cls_sum[EM_BITS-1:0]};
      cls_flags = '0;
      case (cls_kind)
         K_NAN: begin
            cls_p               = QNAN;
            cls_flags[FLAG_NAN] = 1'b1;
         end
         K_INF: begin
            cls_p               = {cls_sign, INF_EM};
            cls_flags[FLAG_OVF] = 1'b1;
         end
         K_ZERO: begin
            cls_p                = {cls_sign, {EM_BITS{1'b0}}};
            cls_flags[FLAG_ZERO] = 1'b1;
         end
         default: begin
            if (cls_sum >= OVF_TH) begin
               cls_p               = {cls_sign, INF_EM};
               cls_flags[FLAG_OVF] = 1'b1;
            end else if (cls_sum < MIN_NORM) begin
               cls_p                = {cls_sign, {EM_BITS{1'b0}}};
               cls_flags[FLAG_ZERO] = 1'b1;
            end
         end
      endcase
   end

endmodule

// File: rtl/lmul_pipe.sv
// Three-stage, LANES-wide approximate float multiplier with valid/ready flow control.
// One global enable advances every stage together, so all lanes stay in lockstep.
module lmul_pipe
   import lmul_pkg::*;
#(
   parameter int E_BITS  = 8,
   parameter int M_BITS  = 7,
   parameter int EM_BITS = E_BITS + M_BITS,
   parameter int BITW    = EM_BITS + 1,
   parameter int LANES   = 4
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [LANES*BITW-1:0]    i_a,
   input  logic [LANES*BITW-1:0]    i_b,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [LANES*BITW-1:0]    o_p,
   output logic [LANES*N_FLAGS-1:0] o_flags
);

   localparam int SW = EM_BITS + 2;

   logic en;
   logic p1_valid, p2_valid, p3_valid;

   logic [LANES-1:0]              p1_sign, p2_sign;
   logic [LANES-1:0][EM_BITS-1:0] p1_em_a, p1_em_b;
   logic [LANES-1:0][SW-1:0]      p2_sum;
   kind_t                         p1_kind [LANES];
   kind_t                         p2_kind [LANES];

   logic [LANES-1:0]              dec_sign;
   logic [LANES-1:0][EM_BITS-1:0] dec_em_a, dec_em_b;
   kind_t                         dec_kind [LANES];
   logic [LANES-1:0][SW-1:0]      add_sum;
   logic [LANES-1:0][BITW-1:0]    cls_p;
   logic [LANES-1:0][N_FLAGS-1:0] cls_flags;

   // s_ready is combinational from m_ready through en.
   assign en      = !p3_valid || m_ready;
   assign s_ready = en;
   assign m_valid = p3_valid;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      lmul_lane #(
         .E_BITS  (E_BITS),
         .M_BITS  (M_BITS),
         .EM_BITS (EM_BITS),
         .BITW    (BITW),
         .SW      (SW)
      ) u_lane (
         .a         (i_a[k*BITW +: BITW]),
         .b         (i_b[k*BITW +: BITW]),
         .dec_sign  (dec_sign[k]),
         .dec_em_a  (dec_em_a[k]),
         .dec_em_b  (dec_em_b[k]),
         .dec_kind  (dec_kind[k]),
         .add_em_a  (p1_em_a[k]),
         .add_em_b  (p1_em_b[k]),
         .add_sum   (add_sum[k]),
         .cls_kind  (p2_kind[k]),
         .cls_sign  (p2_sign[k]),
         .cls_sum   (p2_sum[k]),
         .cls_p     (cls_p[k]),
         .cls_flags (cls_flags[k])
      );
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         p1_valid <= 1'b0;
         p2_valid <= 1'b0;
         p3_valid <= 1'b0;
         o_p      <= '0;
         o_flags  <= '0;
      end else if (en) begin
         p1_valid <= s_valid;
         p2_valid <= p1_valid;
         p3_valid <= p2_valid;
         p1_sign  <= dec_sign;
         p1_em_a  <= dec_em_a;
         p1_em_b  <= dec_em_b;
         p2_sign  <= p1_sign;
         p2_sum   <= add_sum;
         for (int k = 0; k < LANES; k++) begin
            p1_kind[k] <= dec_kind[k];
            p2_kind[k] <= p1_kind[k];
         end
         o_p     <= cls_p;
         o_flags <= cls_flags;
      end
   end

endmodule
